// File: rtl/div_pause_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU that holds the pipeline via pause/unpause.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass the iteration loop.
module div_pause_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            pause_signal,
  output logic            unpause_signal,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd,
  output logic            result_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  div_mag;
  logic [4:0]       rd_r;
  logic             is_rem_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dz_r;
  logic             ovf_r;

  // Operand decode for the accepting cycle
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            dz_in;
  logic            ovf_in;
  logic            accept;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign abs_a     = a_neg ? (~dividend + 1'b1) : dividend;
  assign abs_b     = b_neg ? (~divisor + 1'b1) : divisor;
  assign dz_in     = (divisor == '0);
  assign ovf_in    = is_signed & (dividend == MIN_VAL) & (divisor == ONES_VAL);
  assign accept    = rst & (state == S_IDLE) & start & ~flush;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor magnitude
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_sub;
  logic            step_ge;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  assign rem_shift = {rem_r, quo_r[XLEN-1]};
  assign step_ge   = (rem_shift >= {1'b0, div_mag});
  // The true difference is below div_mag whenever step_ge holds, so XLEN bits suffice.
  assign rem_sub   = rem_shift[XLEN-1:0] - div_mag;
  assign rem_step  = step_ge ? rem_sub : rem_shift[XLEN-1:0];
  assign quo_step  = {quo_r[XLEN-2:0], step_ge};

  // Sign and special-case correction of the final magnitudes
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] res_val;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    quo_fix = quo_r;
    rem_fix = rem_r;
    res_val = '0;
    if (q_neg_r && !dz_r) quo_fix = ~quo_r + 1'b1;
    if (r_neg_r)          rem_fix = ~rem_r + 1'b1;
    if (ovf_r)            res_val = is_rem_r ? '0 : MIN_VAL;
    else                  res_val = is_rem_r ? rem_fix : quo_fix;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      div_mag  <= '0;
      rd_r     <= '0;
      is_rem_r <= 1'b0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            div_mag  <= abs_b;
            rd_r     <= rd_in;
            is_rem_r <= op[1];
            q_neg_r  <= a_neg ^ b_neg;
            r_neg_r  <= a_neg;
            dz_r     <= dz_in;
            ovf_r    <= ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
            if (dz_in || ovf_in) begin
              // Preload the magnitudes the full iteration would have produced.
              quo_r <= dz_in ? ONES_VAL : MIN_VAL;
              rem_r <= dz_in ? abs_a : '0;
              state <= S_DONE;
            end else begin
              quo_r <= abs_a;
              rem_r <= '0;
              state <= S_CALC;
            end
`else
            quo_r <= abs_a;
            rem_r <= '0;
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem_r <= rem_step;
            quo_r <= quo_step;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Controller handshake: pause and unpause are mutually exclusive by construction.
  assign pause_signal   = accept | (rst & (state == S_CALC) & ~flush);
  assign unpause_signal = ((state == S_CALC) & flush) | (state == S_DONE);
  assign busy           = (state != S_IDLE);
  assign result_valid   = (state == S_DONE) & ~flush;
  assign result         = (state == S_DONE) ? res_val : '0;
  assign result_rd      = (state == S_DONE) ? rd_r : '0;

endmodule

// File: tb/tb_div_pause_unit.sv
// Self-checking bench for div_pause_unit: directed RV32M cases, flush/reset scenarios and random operations.
module tb_div_pause_unit;

  localparam int XLEN = 32;
`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'd0;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
  logic [4:0]      rd_in = '0;
  logic            flush = 1'b0;
  logic            pause_signal;
  logic            unpause_signal;
  logic            busy;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;
  logic            result_valid;

  int total = 0;
  int bad   = 0;

  div_pause_unit #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .dividend       (dividend),
    .divisor        (divisor),
    .rd_in          (rd_in),
    .flush          (flush),
    .pause_signal   (pause_signal),
    .unpause_signal (unpause_signal),
    .busy           (busy),
    .result         (result),
    .result_rd      (result_rd),
    .result_valid   (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // RV32M semantics from the ISA rules, using the simulator's own arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic is_rem;
    logic uns;
    is_rem = o[1];
    uns    = o[0];
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (uns) return is_rem ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
    return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (FAST && special) ? 1 : XLEN + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation in the current cycle and checks the whole handshake up to the return to idle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int restart_at);
    int lat;
    int hold_bad;
    logic [31:0] expv;
    lat      = latency(o, a, b);
    expv     = model(o, a, b);
    hold_bad = 0;
    op = o; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
    #1;
    check("c0_pause", 32'(pause_signal), 32'd1);
    check("c0_unpause", 32'(unpause_signal), 32'd0);
    for (int c = 1; c < lat; c++) begin
      step();
      start    = (c == restart_at);
      op       = (c == restart_at) ? ~o : o;
      dividend = $urandom;
      divisor  = $urandom | 32'd1;
      rd_in    = ~rd;
      #1;
      if (pause_signal !== 1'b1 || unpause_signal !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1)
        hold_bad++;
    end
    check("hold_cycles", 32'(hold_bad), 32'd0);
    step();
    start = 1'b0;
    #1;
    check("done_valid", 32'(result_valid), 32'd1);
    check("done_unpause", 32'(unpause_signal), 32'd1);
    check("done_pause", 32'(pause_signal), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_result", result, expv);
    check("done_rd", 32'(result_rd), 32'(rd));
    step();
    #1;
    check("after_busy", 32'(busy), 32'd0);
    check("after_unpause", 32'(unpause_signal), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    int nz;
    nz = 0;
    if (pause_signal !== 1'b0) nz++;
    if (unpause_signal !== 1'b0) nz++;
    if (busy !== 1'b0) nz++;
    if (result_valid !== 1'b0) nz++;
    if (result !== '0) nz++;
    if (result_rd !== '0) nz++;
    check(tag, 32'(nz), 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset held with start asserted: everything stays quiet.
    rst = 1'b0; start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
    step(); step();
    #1;
    check_all_zero("reset_outputs");
    start = 1'b0;
    rst   = 1'b1;
    step();

    // Directed cases
    run_op(2'b01, 32'd100, 32'd7, 5'd11, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    run_op(2'b00, 32'd5, 32'd0, 5'd6, 0);
    run_op(2'b10, 32'd5, 32'd0, 5'd7, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd10, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd12, 0);

    // start re-asserted mid-operation is ignored
    run_op(2'b01, 32'd1000, 32'd33, 5'd20, 5);

    // Flush in cycle 10, then a fresh start in cycle 11
    op = 2'b01; dividend = 32'd500; divisor = 32'd9; rd_in = 5'd1; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush_unpause", 32'(unpause_signal), 32'd1);
    check("flush_pause", 32'(pause_signal), 32'd0);
    check("flush_valid", 32'(result_valid), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    run_op(2'b00, 32'hFFFF_FF00, 32'd16, 5'd2, 0);

    // Flush in the DONE cycle suppresses the strobe
    op = 2'b11; dividend = 32'd77; divisor = 32'd10; rd_in = 5'd13; start = 1'b1;
    for (int c = 1; c <= XLEN + 1; c++) begin
      step();
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flushdone_valid", 32'(result_valid), 32'd0);
    check("flushdone_unpause", 32'(unpause_signal), 32'd1);
    step();
    flush = 1'b0;
    #1;
    check("flushdone_busy", 32'(busy), 32'd0);

    // Flush together with start in idle: start dropped
    op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    check("idleflush_pause", 32'(pause_signal), 32'd0);
    check("idleflush_unpause", 32'(unpause_signal), 32'd0);
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    check("idleflush_busy", 32'(busy), 32'd0);

    // Reset asserted in cycle 20 of an operation
    op = 2'b01; dividend = 32'd12345; divisor = 32'd67; rd_in = 5'd30; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_all_zero("midreset_now");
    step();
    check_all_zero("midreset_next");
    rst = 1'b1;
    step();
    run_op(2'b11, 32'd12345, 32'd67, 5'd31, 0);

    // Randomized operations, biased toward special operands
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, 5'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_pause_unit.md
Name: div_pause_unit

Overview:
- Iterative radix-2 divider implementing RV32M DIV/DIVU/REM/REMU in the execute stage.
- Drives the pipeline controller's pause request interface: it raises pause_signal while the operation is in flight and pulses unpause_signal when it completes or aborts.
- Consumes the controller's flush output to abort in-flight work.
- The pipeline stays frozen between start and result_valid.

Parameters:
- XLEN, 32, operand and result width; must be a power of two, 8 or more.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; state is cleared while low.
- start  in  1  request a divide this cycle.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- rd_in  in  5  destination register tag.
- flush  in  1  pipeline flush from the controller; aborts the operation.
- pause_signal  out  1  pause request to the controller.
- unpause_signal  out  1  release request to the controller, one-cycle pulse.
- busy  out  1  operation in flight.
- result  out  XLEN  quotient or remainder.
- result_rd  out  5  latched rd_in.
- result_valid  out  1  result strobe, one cycle.

Behaviour:
- Reset (rst=0): state IDLE, counter 0, all outputs 0, operand registers 0.
- States: IDLE, CALC, DONE.
- IDLE, start=1 and flush=0:
  - pause_signal=1 combinationally in the same cycle.
  - Latch op and rd_in, the absolute values for signed ops, and the quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
  - Next state CALC, counter=0.
- IDLE, start=1 and flush=1: start is ignored, no pause request.
- CALC:
  - Each cycle runs one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor magnitude, set the quotient bit if the remainder is 0 or more.
  - Counter increments each cycle; after XLEN steps go to DONE.
  - pause_signal=1 and busy=1 throughout.
- DONE (one cycle):
  - result_valid=1, unpause_signal=1, pause_signal=0, busy=1.
  - result is the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
  - result_rd is the latched tag.
  - Next state IDLE.
- Latency:
  - start in cycle 0 gives result_valid in cycle XLEN+1.
  - A new start is accepted in cycle XLEN+2.
- Special values are identical with and without the optional feature:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (dividend 0x80000000, divisor all ones, DIV/REM): DIV gives 0x80000000, REM gives 0.
- Sign rule: negate the quotient if the quotient sign is set and the divisor is nonzero; negate the remainder if the dividend sign is set; unsigned ops never negate.
- start while busy: ignored; operands are not re-latched.
- flush in CALC or DONE:
  - That cycle: unpause_signal=1, pause_signal=0, result_valid forced to 0.
  - Next state IDLE.
- flush in IDLE: no effect, no outputs.
- unpause_signal and pause_signal are never 1 in the same cycle.
- rst going low mid-operation: immediate IDLE, all outputs 0, no unpause pulse.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: divisor 0 and signed overflow skip CALC.
  - IDLE goes to DONE directly; result_valid in cycle 1.
  - pause_signal is high in cycle 0 only; unpause_signal is pulsed in cycle 1.
- Undefined: special cases run the full XLEN iterations with latency XLEN+1.
  - Divisor 0 produces its value naturally.
  - Overflow is corrected in DONE.

Test Plan:
- DIVU 100/7 (XLEN=32), start in cycle 0 -> pause_signal=1 in cycles 0..32; cycle 33: result=14, result_valid=1, unpause_signal=1, result_rd=latched tag.
- DIV -7/2, then REM -7/2 -> results 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1); REMU 0xFFFFFFF9/2 -> 1.
- DIV 5/0 and REM 5/0 -> 0xFFFFFFFF and 5; valid in cycle 1 with DIV_FAST_SPECIAL_EN, cycle 33 without.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start, flush in cycle 10 -> cycle 10: unpause_signal=1, pause_signal=0, no result_valid; cycle 11: busy=0; a new start in cycle 11 is accepted and completes correctly.
- start re-asserted with different operands in cycle 5 -> ignored, original result delivered; rst low in cycle 20 -> all outputs 0 at once, no unpause pulse.
